// File: rtl/variable_table_manager.sv
// variable_table_manager: resolves a streamed variable name against a fixed-stride
// symbol table in shared data memory, then reads, writes or declares its typed value.
// Optional feature macro: VTM_HIT_CACHE_EN (last-resolved-name cache that skips the scan).
// Ports:
//   Clk, Rst                  clock (rising edge), asynchronous active-high reset
//   Start, Name               start pulse, then one name char per cycle, 8'h00 terminates
//   InMode, InType, InValue   operation (01 read, 10 write, 11 declare), type, value; taken with terminator
//   OutValue, OutType, OutAddr result value, stored type, value-word address
//   Ready, Error              one-cycle done pulse; 00 ok, 01 not found, 10 table full, 11 name too long
//   req, grt                  bus request / grant
//   MemAddrBus, MemWriteBus, WDMB, RDMB  tri-stated memory bus drivers; MemReadBus read data
module variable_table_manager #(
  parameter int unsigned     DATA_W    = 32,
  parameter int unsigned     ADDR_W    = 32,
  parameter int unsigned     NAME_LEN  = 8,
  parameter int unsigned     DEPTH     = 16,
  parameter longint unsigned BASE_ADDR = 64'h8000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic [7:0]        Name,
  input  logic [1:0]        InMode,
  input  logic [1:0]        InType,
  input  logic [DATA_W-1:0] InValue,
  output logic [DATA_W-1:0] OutValue,
  output logic [1:0]        OutType,
  output logic [ADDR_W-1:0] OutAddr,
  output logic              Ready,
  output logic [1:0]        Error,
  output logic              req,
  input  logic              grt,
  output tri   [ADDR_W-1:0] MemAddrBus,
  output tri   [DATA_W-1:0] MemWriteBus,
  input  logic [DATA_W-1:0] MemReadBus,
  output tri   [1:0]        WDMB,
  output tri   [1:0]        RDMB
);

  localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WW     = $clog2(NAME_LEN + 2);
  localparam int unsigned CW     = $clog2(NAME_LEN + 1);
  localparam int unsigned STRIDE = NAME_LEN + 2;

  typedef enum logic [3:0] {
    S_IDLE, S_NAME, S_NERR, S_REQ, S_SRD, S_SCK, S_ARD, S_ACK, S_WR, S_DONE
  } state_t;

  state_t                     state, state_n;
  logic [CW-1:0]              cnt, cnt_n;
  logic [NAME_LEN-1:0][7:0]   nbuf, nbuf_n;
  logic [1:0]                 mode, mode_n, itype, itype_n;
  logic [DATA_W-1:0]          ivalue, ivalue_n;
  logic [IW-1:0]              idx, idx_n, free_idx, free_idx_n;
  logic [WW-1:0]              widx, widx_n;
  logic                       free_found, free_found_n, creating, creating_n;
  logic [DATA_W-1:0]          out_value_n;
  logic [1:0]                 out_type_n, error_n;
  logic [ADDR_W-1:0]          out_addr_n;
  logic                       ready_n, req_n;
`ifdef VTM_HIT_CACHE_EN
  logic [NAME_LEN-1:0][7:0]   cname, cname_n;
  logic [IW-1:0]              cidx, cidx_n;
  logic                       cvalid, cvalid_n;
`endif

  logic              own, rd, wr, hit, miss, next_entry;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        cur_char;

  // Bus is driven only while we request it and hold the grant.
  assign own         = req & grt;
  assign mem_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(idx) * ADDR_W'(STRIDE) + ADDR_W'(widx);
  assign MemAddrBus  = own ? mem_addr : {ADDR_W{1'bz}};
  assign MemWriteBus = own ? mem_wdata : {DATA_W{1'bz}};
  assign RDMB        = own ? {1'b0, rd} : 2'bzz;
  assign WDMB        = own ? {1'b0, wr} : 2'bzz;

  // Name character that belongs to entry word widx (words 1..NAME_LEN).
  always_comb begin
    cur_char = 8'h00;
    for (int i = 0; i < int'(NAME_LEN); i++)
      if (widx == WW'(i + 1)) cur_char = nbuf[i];
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      nbuf       <= '0;
      mode       <= '0;
      itype      <= '0;
      ivalue     <= '0;
      idx        <= '0;
      widx       <= '0;
      free_idx   <= '0;
      free_found <= 1'b0;
      creating   <= 1'b0;
      OutValue   <= '0;
      OutType    <= '0;
      OutAddr    <= '0;
      Ready      <= 1'b0;
      Error      <= '0;
      req        <= 1'b0;
`ifdef VTM_HIT_CACHE_EN
      cname      <= '0;
      cidx       <= '0;
      cvalid     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      nbuf       <= nbuf_n;
      mode       <= mode_n;
      itype      <= itype_n;
      ivalue     <= ivalue_n;
      idx        <= idx_n;
      widx       <= widx_n;
      free_idx   <= free_idx_n;
      free_found <= free_found_n;
      creating   <= creating_n;
      OutValue   <= out_value_n;
      OutType    <= out_type_n;
      OutAddr    <= out_addr_n;
      Ready      <= ready_n;
      Error      <= error_n;
      req        <= req_n;
`ifdef VTM_HIT_CACHE_EN
      cname      <= cname_n;
      cidx       <= cidx_n;
      cvalid     <= cvalid_n;
`endif
    end
  end

  // Next-state, bus strobes and registered-output updates.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    nbuf_n       = nbuf;
    mode_n       = mode;
    itype_n      = itype;
    ivalue_n     = ivalue;
    idx_n        = idx;
    widx_n       = widx;
    free_idx_n   = free_idx;
    free_found_n = free_found;
    creating_n   = creating;
    out_value_n  = OutValue;
    out_type_n   = OutType;
    out_addr_n   = OutAddr;
    ready_n      = 1'b0;
    error_n      = Error;
    req_n        = req;
`ifdef VTM_HIT_CACHE_EN
    cname_n      = cname;
    cidx_n       = cidx;
    cvalid_n     = cvalid;
`endif
    rd         = 1'b0;
    wr         = 1'b0;
    mem_wdata  = '0;
    hit        = 1'b0;
    miss       = 1'b0;
    next_entry = 1'b0;

    case (state)
      S_IDLE: if (Start) begin
        state_n = S_NAME;
        cnt_n   = '0;
        nbuf_n  = '0;
      end
      S_NAME: begin
        if (Name == 8'h00) begin
          mode_n   = InMode;
          itype_n  = InType;
          ivalue_n = InValue;
          req_n    = 1'b1;
          state_n  = S_REQ;
        end else if (cnt == CW'(NAME_LEN)) begin
          state_n = S_NERR;
        end else begin
          for (int i = 0; i < int'(NAME_LEN); i++)
            if (cnt == CW'(i)) nbuf_n[i] = Name;
          cnt_n = cnt + CW'(1);
        end
      end
      // Overlong name: swallow the rest of it without touching the bus.
      S_NERR: if (Name == 8'h00) begin
        error_n = 2'b11;
        ready_n = 1'b1;
        state_n = S_DONE;
      end
      S_REQ: if (own) begin
        idx_n        = '0;
        widx_n       = '0;
        free_found_n = 1'b0;
        creating_n   = 1'b0;
        state_n      = S_SRD;
`ifdef VTM_HIT_CACHE_EN
        if (cvalid && (cname == nbuf)) begin
          idx_n = cidx;
          hit   = 1'b1;
        end
`endif
      end
      S_SRD: if (own) begin
        rd      = 1'b1;
        state_n = S_SCK;
      end
      // Read data for the word issued in S_SRD is valid here.
      S_SCK: begin
        if (widx == '0) begin
          if (MemReadBus[2]) begin
            widx_n  = WW'(1);
            state_n = S_SRD;
          end else begin
            if (!free_found) begin
              free_found_n = 1'b1;
              free_idx_n   = idx;
            end
            next_entry = 1'b1;
          end
        end else if (MemReadBus != DATA_W'(cur_char)) begin
          next_entry = 1'b1;
        end else if (widx == WW'(NAME_LEN)) begin
          hit = 1'b1;
        end else begin
          widx_n  = widx + WW'(1);
          state_n = S_SRD;
        end
        if (next_entry) begin
          if (idx == IW'(DEPTH - 1)) begin
            miss = 1'b1;
          end else begin
            idx_n   = idx + IW'(1);
            widx_n  = '0;
            state_n = S_SRD;
          end
        end
      end
      // Read access: fetch w0 for the type, then the value word.
      S_ARD: if (own) begin
        rd      = 1'b1;
        state_n = S_ACK;
      end
      S_ACK: begin
        if (widx == '0) begin
          out_type_n = MemReadBus[1:0];
          widx_n     = WW'(NAME_LEN + 1);
          state_n    = S_ARD;
        end else begin
          out_value_n = MemReadBus;
          out_addr_n  = mem_addr;
          error_n     = 2'b00;
          ready_n     = 1'b1;
          req_n       = 1'b0;
          state_n     = S_DONE;
        end
      end
      // Writes w0 then the value word; a create also writes every name word in between.
      S_WR: if (own) begin
        wr = 1'b1;
        if (widx == '0)                      mem_wdata = DATA_W'({1'b1, itype});
        else if (widx == WW'(NAME_LEN + 1))  mem_wdata = ivalue;
        else                                 mem_wdata = DATA_W'(cur_char);
        if (widx == WW'(NAME_LEN + 1)) begin
          out_value_n = ivalue;
          out_type_n  = itype;
          out_addr_n  = mem_addr;
          error_n     = 2'b00;
          ready_n     = 1'b1;
          req_n       = 1'b0;
          state_n     = S_DONE;
        end else begin
          widx_n = creating ? widx + WW'(1) : WW'(NAME_LEN + 1);
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (hit) begin
      widx_n  = '0;
      state_n = mode[1] ? S_WR : S_ARD;
`ifdef VTM_HIT_CACHE_EN
      cname_n  = nbuf;
      cidx_n   = idx_n;
      cvalid_n = 1'b1;
`endif
    end

    if (miss) begin
      if ((mode == 2'b11) && free_found_n) begin
        creating_n = 1'b1;
        idx_n      = free_idx_n;
        widx_n     = '0;
        state_n    = S_WR;
`ifdef VTM_HIT_CACHE_EN
        cvalid_n   = 1'b0;
`endif
      end else begin
        error_n = (mode == 2'b11) ? 2'b10 : 2'b01;
        ready_n = 1'b1;
        req_n   = 1'b0;
        state_n = S_DONE;
      end
    end
  end

endmodule
